// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, fill FSM states and line type for the refill engine
package cache_pkg;

    // Geometry of one cache line
    localparam int NrWordsPerLine = 4;
    localparam int LineSize       = 32 * NrWordsPerLine;
    localparam int ByteOffsetBits = $clog2(NrWordsPerLine * 4);
    localparam int BeatBits       = $clog2(NrWordsPerLine);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} fill_state_e;

    typedef logic [LineSize-1:0] line_t;

endpackage

// File: rtl/line_fill_unit.sv
// rtl/line_fill_unit.sv - line refill engine between the read cache and a 32-bit word bus
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   mem_addr_i, mem_read_en_i line request from the cache (one-cycle pulse)
//   mem_read_valid_o          one-cycle pulse, mem_read_data_o holds the full line
//   mem_read_data_o           returned line, word k at [32k+31:32k]
//   bus_req_o, bus_addr_o     word read request, held until bus_gnt_i
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i               bus grant, read data valid and read data
//   busy_o                    fill in progress
//
// Build option: LINE_FILL_LAST_LINE_EN keeps the last filled line so a repeat
// request for the same line returns without any bus traffic.
module line_fill_unit
    import cache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         mem_addr_i,
    input  logic                mem_read_en_i,
    output logic                mem_read_valid_o,
    output logic [LineSize-1:0] mem_read_data_o,
    output logic                bus_req_o,
    output logic [31:0]         bus_addr_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [31:0]         bus_rdata_i,
    output logic                busy_o
);

    fill_state_e                state_q;
    logic [BeatBits-1:0]        beat_q;
    logic [31:ByteOffsetBits]   base_q;
    line_t                      line_q;
    line_t                      data_q;

    logic                       capture;
    logic                       last_beat;
    line_t                      line_upd;

    // Byte offset inside the line is irrelevant for a line request
    logic                       unused_addr_bits;
    assign unused_addr_bits = ^mem_addr_i[ByteOffsetBits-1:0];

`ifdef LINE_FILL_LAST_LINE_EN
    // data_q already holds the last returned line; only its base and a valid bit are added
    logic                       last_valid_q;
    logic [31:ByteOffsetBits]   last_base_q;
    logic                       hit;
    assign hit = last_valid_q && (mem_addr_i[31:ByteOffsetBits] == last_base_q);
`endif

    assign last_beat = (beat_q == BeatBits'(NrWordsPerLine - 1));

    // A word is taken in WAIT, or directly in REQ when grant and data coincide
    always_comb begin
        capture  = ((state_q == REQ) && bus_gnt_i && bus_rvalid_i) ||
                   ((state_q == WAIT) && bus_rvalid_i);
        line_upd = line_q;
        line_upd[{beat_q, 5'b00000} +: 32] = bus_rdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            line_q       <= '0;
            data_q       <= '0;
`ifdef LINE_FILL_LAST_LINE_EN
            last_valid_q <= 1'b0;
            last_base_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read_en_i) begin
                        base_q  <= mem_addr_i[31:ByteOffsetBits];
                        beat_q  <= '0;
`ifdef LINE_FILL_LAST_LINE_EN
                        state_q <= hit ? RESP : REQ;
`else
                        state_q <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (bus_gnt_i && !bus_rvalid_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Word capture overrides the state decision above
            if (capture) begin
                line_q <= line_upd;
                if (last_beat) begin
                    data_q       <= line_upd;
                    state_q      <= RESP;
`ifdef LINE_FILL_LAST_LINE_EN
                    last_valid_q <= 1'b1;
                    last_base_q  <= base_q;
`endif
                end else begin
                    beat_q  <= beat_q + 1'b1;
                    state_q <= REQ;
                end
            end
        end
    end

    // Beat index sits in the word-address bits, so the address never leaves the line
    assign bus_addr_o       = {base_q, beat_q, 2'b00};
    assign bus_req_o        = (state_q == REQ);
    assign busy_o           = (state_q != IDLE);
    assign mem_read_valid_o = (state_q == RESP);
    assign mem_read_data_o  = data_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// tb/tb_line_fill_unit.sv - self-checking bench for line_fill_unit with a bus responder and line model
module tb_line_fill_unit;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_read_valid;
    line_t       mem_read_data;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Responder configuration
    int                  gnt_wait  = 0;
    int                  rv_lat    = 0;
    int                  stall_len = 0;
    logic                stall_en  = 1'b0;
    logic [BeatBits-1:0] stall_beat = '0;
    int                  stall_obs = 0;
    logic                fixed_data = 1'b0;
    logic [31:0]         seed = 32'h0;

    // Responder state
    logic        rv_pending = 1'b0;
    int          rv_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] rv_addr;
    logic [31:0] held_addr;
    logic [31:0] addr_log[$];

    // Results of the last run_fill
    int    lat;
    int    pulses;
    logic  req_seen;
    line_t line;
    line_t early;
    logic  bav;
    line_t prev_line;

    line_fill_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_addr_i       (mem_addr),
        .mem_read_en_i    (mem_read_en),
        .mem_read_valid_o (mem_read_valid),
        .mem_read_data_o  (mem_read_data),
        .bus_req_o        (bus_req),
        .bus_addr_o       (bus_addr),
        .bus_gnt_i        (bus_gnt),
        .bus_rvalid_i     (bus_rvalid),
        .bus_rdata_i      (bus_rdata),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_data) return 32'hA0 + {28'h0, a[5:2]} - {28'h0, a[5:4], 2'b00};
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Reference line: every word of the aligned line read from the memory model
    function automatic line_t exp_line(input logic [31:0] a);
        line_t       l;
        logic [31:0] b;
        b = a & ~(32'(NrWordsPerLine * 4) - 32'd1);
        for (int k = 0; k < NrWordsPerLine; k++) l[32*k +: 32] = mem_word(b + 32'(4 * k));
        return l;
    endfunction

    function automatic int exp_lat(input int gw, input int rl, input int extra);
        return 1 + NrWordsPerLine * (gw + 1 + rl) + 1 + extra;
    endfunction

    // Bus responder: decides gnt/rvalid for the coming edge at every falling edge
    initial begin
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            int w;
            @(negedge clk);
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata = $urandom;
            if (rst) begin
                rv_pending = 1'b0;
                req_cnt = 0;
            end else if (rv_pending) begin
                if (rv_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata = mem_word(rv_addr);
                    rv_pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (bus_req) begin
                w = (stall_en && bus_addr[ByteOffsetBits-1:2] == stall_beat) ? stall_len : gnt_wait;
                if (req_cnt == 0) begin
                    held_addr = bus_addr;
                end else begin
                    checks++;
                    stall_obs++;
                    if (bus_addr !== held_addr || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL req_hold: addr %h busy %b, expected addr %h busy 1", bus_addr, busy, held_addr);
                    end
                end
                if (req_cnt < w) begin
                    req_cnt++;
                end else begin
                    bus_gnt = 1'b1;
                    req_cnt = 0;
                    addr_log.push_back(bus_addr);
                    if (rv_lat == 0) begin
                        bus_rvalid = 1'b1;
                        bus_rdata = mem_word(bus_addr);
                    end else begin
                        rv_pending = 1'b1;
                        rv_cnt = rv_lat - 1;
                        rv_addr = bus_addr;
                    end
                end
            end
        end
    end

    // Issue one request and observe until the valid pulse plus a few cycles
    task automatic run_fill(input logic [31:0] addr, input int inject_at, input logic [31:0] inj_addr);
        addr_log.delete();
        lat = 0;
        pulses = 0;
        req_seen = 1'b0;
        line = '0;
        bav = 1'b0;
        @(negedge clk);
        mem_addr = addr;
        mem_read_en = 1'b1;
        @(negedge clk);
        mem_read_en = 1'b0;
        early = mem_read_data;
        for (int n = 1; n < 400; n++) begin
            if (bus_req) req_seen = 1'b1;
            if (mem_read_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = n + 1;
                    line = mem_read_data;
                    bav = busy;
                end
            end
            if (n == inject_at) begin
                mem_read_en = 1'b1;
                mem_addr = inj_addr;
            end else begin
                mem_read_en = 1'b0;
            end
            if (lat != 0 && n >= lat + 3) break;
            @(negedge clk);
        end
        mem_read_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read_en = 1'b0;
        mem_addr = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_read_valid, bus_req, busy} !== 3'b000 || mem_read_data !== '0 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid %b req %b busy %b addr %h data %h, expected all 0",
                     mem_read_valid, bus_req, busy, bus_addr, mem_read_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        line_t want;
        fixed_data = 1'b1;
        gnt_wait = 1;
        rv_lat = 2;
        want = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        run_fill(32'h0000_1234, 0, 32'h0);
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL basic_beats: got %0d bus beats, expected 4", addr_log.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (addr_log[k] !== 32'h1230 + 32'(4 * k)) begin
                errors++;
                $display("FAIL basic_addr%0d: got %h expected %h", k, addr_log[k], 32'h1230 + 32'(4 * k));
            end
        end
        checks++;
        if (line !== want) begin
            errors++;
            $display("FAIL basic_line: got %h expected %h", line, want);
        end
        checks++;
        if (pulses != 1 || lat != exp_lat(1, 2, 0)) begin
            errors++;
            $display("FAIL basic_pulse: got %0d pulses latency %0d, expected 1 pulse latency %0d",
                     pulses, lat, exp_lat(1, 2, 0));
        end
        fixed_data = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        a = $urandom;
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 0;
        run_fill(a, 0, 32'h0);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL zero_wait_latency: got %0d expected 6", lat);
        end
        checks++;
        if (line !== exp_line(a) || pulses != 1) begin
            errors++;
            $display("FAIL zero_wait_line: got %h (%0d pulses) expected %h (1 pulse)", line, pulses, exp_line(a));
        end
    endtask

    task automatic test_second_request();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = a & ~(32'(NrWordsPerLine * 4) - 32'd1);
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 1;
        run_fill(a, 3, a ^ 32'h0000_0100);
        for (int k = 0; k < NrWordsPerLine; k++) begin
            checks++;
            if (addr_log[k] !== b + 32'(4 * k)) begin
                errors++;
                $display("FAIL second_req_addr%0d: got %h expected %h", k, addr_log[k], b + 32'(4 * k));
            end
        end
        checks++;
        if (addr_log.size() != NrWordsPerLine || pulses != 1 || line !== exp_line(a)) begin
            errors++;
            $display("FAIL second_req_line: beats %0d pulses %0d line %h, expected beats 4 pulses 1 line %h",
                     addr_log.size(), pulses, line, exp_line(a));
        end
    endtask

    task automatic test_request_at_resp();
        logic [31:0] a;
        a = $urandom;
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 0;
        run_fill(a, 5, a ^ 32'h0001_0000);
        checks++;
        if (bav !== 1'b1 || pulses != 1 || addr_log.size() != NrWordsPerLine || busy !== 1'b0) begin
            errors++;
            $display("FAIL resp_request: busy_at_valid %b pulses %0d beats %0d busy_after %b, expected 1 1 4 0",
                     bav, pulses, addr_log.size(), busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] a;
        logic        found;
        a = $urandom;
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 2;
        found = 1'b0;
        @(negedge clk);
        mem_addr = a;
        mem_read_en = 1'b1;
        @(negedge clk);
        mem_read_en = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (bus_req && bus_addr[ByteOffsetBits-1:2] == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach_beat2: got no beat-2 request, expected one");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_read_valid, bus_req, busy} !== 3'b000 || mem_read_data !== '0 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid %b req %b busy %b addr %h data %h, expected all 0",
                     mem_read_valid, bus_req, busy, bus_addr, mem_read_data);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_read_valid) pulses++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_read_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_no_valid: got %0d pulses expected 0", pulses);
        end
        a = $urandom;
        rv_lat = 1;
        run_fill(a, 0, 32'h0);
        checks++;
        if (addr_log[0] !== (a & ~(32'(NrWordsPerLine * 4) - 32'd1)) || line !== exp_line(a) || pulses != 1) begin
            errors++;
            $display("FAIL reset_mid_refill: first addr %h line %h pulses %0d, expected addr %h line %h pulses 1",
                     addr_log[0], line, pulses, a & ~(32'(NrWordsPerLine * 4) - 32'd1), exp_line(a));
        end
    endtask

    task automatic test_last_line();
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 1;
        run_fill(32'h0000_1234, 0, 32'h0);
        run_fill(32'h0000_1230, 0, 32'h0);
`ifdef LINE_FILL_LAST_LINE_EN
        checks++;
        if (lat != 2 || req_seen !== 1'b0 || addr_log.size() != 0) begin
            errors++;
            $display("FAIL last_line_hit: latency %0d req_seen %b beats %0d, expected 2 0 0",
                     lat, req_seen, addr_log.size());
        end
`else
        checks++;
        if (lat != exp_lat(0, 1, 0) || addr_log.size() != NrWordsPerLine) begin
            errors++;
            $display("FAIL refetch_full_fill: latency %0d beats %0d, expected %0d 4",
                     lat, addr_log.size(), exp_lat(0, 1, 0));
        end
`endif
        checks++;
        if (line !== exp_line(32'h1230) || pulses != 1) begin
            errors++;
            $display("FAIL refetch_line: got %h (%0d pulses) expected %h", line, pulses, exp_line(32'h1230));
        end
        run_fill(32'h0000_1240, 0, 32'h0);
        checks++;
        if (lat != exp_lat(0, 1, 0) || addr_log.size() != NrWordsPerLine || addr_log[0] !== 32'h1240 ||
            line !== exp_line(32'h1240)) begin
            errors++;
            $display("FAIL next_line_fill: latency %0d beats %0d addr0 %h line %h, expected %0d 4 00001240 %h",
                     lat, addr_log.size(), addr_log[0], line, exp_lat(0, 1, 0), exp_line(32'h1240));
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        a = $urandom;
        seed = $urandom;
        gnt_wait = 0;
        rv_lat = 1;
        stall_en = 1'b1;
        stall_beat = 1;
        stall_len = 20;
        stall_obs = 0;
        run_fill(a, 0, 32'h0);
        stall_en = 1'b0;
        checks++;
        if (lat != exp_lat(0, 1, 20) || stall_obs < 20) begin
            errors++;
            $display("FAIL stall_latency: latency %0d held cycles %0d, expected %0d and >=20",
                     lat, stall_obs, exp_lat(0, 1, 20));
        end
        checks++;
        if (line !== exp_line(a) || pulses != 1) begin
            errors++;
            $display("FAIL stall_line: got %h (%0d pulses) expected %h", line, pulses, exp_line(a));
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = a & ~(32'(NrWordsPerLine * 4) - 32'd1);
            seed = $urandom;
            gnt_wait = $urandom_range(0, 2);
            rv_lat = $urandom_range(0, 3);
            run_fill(a, 0, 32'h0);
            checks++;
            if (i > 0 && early !== prev_line) begin
                errors++;
                $display("FAIL rand_hold%0d: data %h expected held %h", i, early, prev_line);
            end
            checks++;
            if (line !== exp_line(a) || pulses != 1 || lat != exp_lat(gnt_wait, rv_lat, 0)) begin
                errors++;
                $display("FAIL rand_line%0d: line %h pulses %0d latency %0d, expected %h 1 %0d",
                         i, line, pulses, lat, exp_line(a), exp_lat(gnt_wait, rv_lat, 0));
            end
            for (int k = 0; k < NrWordsPerLine; k++) begin
                checks++;
                if (addr_log[k] !== b + 32'(4 * k)) begin
                    errors++;
                    $display("FAIL rand_addr%0d_%0d: got %h expected %h", i, k, addr_log[k], b + 32'(4 * k));
                end
            end
            prev_line = exp_line(a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_wait();
        test_second_request();
        test_request_at_resp();
        test_reset_mid_fill();
        test_last_line();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
